// File: rtl/fmc_pkg.sv
// Shared definitions for the FMC bus front end: default widths, FSM states and address range check.
package fmc_pkg;

  localparam int unsigned FMC_DATA_W      = 16;
  localparam int unsigned FMC_ADDR_W      = 4;
  localparam int unsigned FMC_SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_DATA = 3'd2,
    S_WR   = 3'd3,
    S_RD   = 3'd4,
    S_HOLD = 3'd5,
    S_ERR  = 3'd6
  } fmc_state_t;

  // True when every bit above the decoded channel index is zero.
  function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned addr_w);
    return (addr >> addr_w) == 32'd0;
  endfunction

endpackage

// File: rtl/fmc_bus_frontend_sync_edge.sv
// N-stage synchroniser for one asynchronous control; rise/fall are registered and line up with sync.
module fmc_sync_edge #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;

  // Edges come from the last two stages so each pulse coincides with the new synced level.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= {STAGES{RST_VAL}};
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      rise  <= chain[STAGES-2] & ~chain[STAGES-1];
      fall  <= ~chain[STAGES-2] & chain[STAGES-1];
    end
  end

  assign sync = chain[STAGES-1];

endmodule

// File: rtl/fmc_bus_frontend.sv
// STM32 FMC multiplexed-bus front end: synchronises the bus, decodes write/read cycles
// for the register bank and drives the AD pad direction.
module fmc_bus_frontend
  import fmc_pkg::*;
#(
  parameter int unsigned DATA_W      = FMC_DATA_W,
  parameter int unsigned ADDR_W      = FMC_ADDR_W,
  parameter int unsigned SYNC_STAGES = FMC_SYNC_STAGES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fpga_nl_nadv,
  input  logic              fpga_cs_ne1,
  input  logic              fpga_wr_nwe,
  input  logic              fpga_rd_noe,
  input  logic [DATA_W-1:0] fpga_db_in,
  output logic [DATA_W-1:0] fpga_db_out,
  output logic              fpga_db_oe,
  output logic              wr_stb,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              bus_err
);

  logic cs_s, cs_rise, cs_fall;
  logic nadv_s, nadv_rise, nadv_fall;
  logic nwe_s, nwe_rise, nwe_fall;
  logic noe_s, noe_rise, noe_fall;
  logic unused_edges;

  fmc_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .din(fpga_cs_ne1), .sync(cs_s), .rise(cs_rise), .fall(cs_fall)
  );
  fmc_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_nadv (
    .clk(clk), .rst(rst), .din(fpga_nl_nadv), .sync(nadv_s), .rise(nadv_rise), .fall(nadv_fall)
  );
  fmc_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_nwe (
    .clk(clk), .rst(rst), .din(fpga_wr_nwe), .sync(nwe_s), .rise(nwe_rise), .fall(nwe_fall)
  );
  fmc_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_noe (
    .clk(clk), .rst(rst), .din(fpga_rd_noe), .sync(noe_s), .rise(noe_rise), .fall(noe_fall)
  );

  assign unused_edges = cs_rise ^ cs_fall ^ nadv_fall ^ noe_rise;

  // Data bus delay matches the control synchronisers so db_s lines up with the synced edges.
  logic [SYNC_STAGES-1:0][DATA_W-1:0] db_pipe;
  logic [DATA_W-1:0]                  db_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      db_pipe <= '0;
    end else begin
      db_pipe <= {db_pipe[SYNC_STAGES-2:0], fpga_db_in};
    end
  end

  assign db_s = db_pipe[SYNC_STAGES-1];

  fmc_state_t        state;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_hold;
  logic              rd_wait;
  logic              oe_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      addr        <= '0;
      data_hold   <= '0;
      rd_wait     <= 1'b0;
      oe_reg      <= 1'b0;
      fpga_db_out <= '0;
      wr_stb      <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      rd_req      <= 1'b0;
      rd_addr     <= '0;
      bus_err     <= 1'b0;
    end else begin
      wr_stb  <= 1'b0;
      rd_req  <= 1'b0;
      bus_err <= 1'b0;
      // Chip select going high ends any cycle silently.
      if (state != S_IDLE && cs_s) begin
        state   <= S_IDLE;
        oe_reg  <= 1'b0;
        rd_wait <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            oe_reg <= 1'b0;
            if (!cs_s && !nadv_s) state <= S_ADDR;
          end
          S_ADDR: begin
            if (nadv_rise) begin
              addr <= db_s[ADDR_W-1:0];
              if (addr_in_range(32'(db_s), ADDR_W)) begin
                state <= S_DATA;
              end else begin
                bus_err <= 1'b1;
                state   <= S_ERR;
              end
            end
          end
          S_DATA: begin
            if (!nwe_s && !noe_s) begin
              bus_err <= 1'b1;
              state   <= S_ERR;
            end else if (nwe_fall) begin
              data_hold <= db_s;
              state     <= S_WR;
            end else if (noe_fall) begin
              rd_req  <= 1'b1;
              rd_addr <= addr;
              rd_wait <= 1'b0;
              state   <= S_RD;
            end
          end
          // data_hold keeps the last sample taken while NWE was low.
          S_WR: begin
            if (nwe_rise) begin
              wr_stb  <= 1'b1;
              wr_addr <= addr;
              wr_data <= data_hold;
              state   <= S_HOLD;
            end else if (!nwe_s) begin
              data_hold <= db_s;
            end
          end
          S_RD: begin
            if (!rd_wait) begin
              rd_wait <= 1'b1;
            end else begin
              fpga_db_out <= rd_data;
              oe_reg      <= 1'b1;
              rd_wait     <= 1'b0;
              state       <= S_HOLD;
            end
          end
          S_HOLD, S_ERR: begin
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // Raw pins release the pad immediately, without synchroniser delay.
  assign fpga_db_oe = oe_reg & ~fpga_cs_ne1 & ~fpga_rd_noe;

endmodule

// File: tb/tb_fmc_bus_frontend.sv
// Directed bench for fmc_bus_frontend with a small register-bank model behind it.
module tb_fmc_bus_frontend;
  import fmc_pkg::*;

  localparam int unsigned NS = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        nadv, cs, nwe, noe;
  logic [15:0] db_in, db_out;
  logic        db_oe;
  logic        wr_stb, rd_req, bus_err;
  logic [3:0]  wr_addr, rd_addr;
  logic [15:0] wr_data, rd_data;

  int n_cmp = 0;
  int n_mis = 0;

  fmc_bus_frontend #(.DATA_W(16), .ADDR_W(4), .SYNC_STAGES(NS)) dut (
    .clk(clk), .rst(rst),
    .fpga_nl_nadv(nadv), .fpga_cs_ne1(cs), .fpga_wr_nwe(nwe), .fpga_rd_noe(noe),
    .fpga_db_in(db_in), .fpga_db_out(db_out), .fpga_db_oe(db_oe),
    .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  // Register bank: writes on wr_stb, read data registered one cycle after rd_req.
  logic [15:0] bank [16];
  always @(posedge clk) begin
    if (wr_stb) bank[wr_addr] <= wr_data;
    if (rd_req) rd_data <= bank[rd_addr];
  end

  int          wr_cnt = 0, rd_cnt = 0, err_cnt = 0;
  logic        oe_seen = 1'b0;
  logic [19:0] wr_q [$];
  logic [3:0]  rd_q [$];

  always @(posedge clk) begin
    #2;
    if (wr_stb) begin wr_cnt++; wr_q.push_back({wr_addr, wr_data}); end
    if (rd_req) begin rd_cnt++; rd_q.push_back(rd_addr); end
    if (bus_err) err_cnt++;
    if (db_oe) oe_seen = 1'b1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic addr_phase(input logic [15:0] a);
    @(negedge clk); cs = 1'b0; nadv = 1'b0; db_in = a;
    repeat (2) @(negedge clk); nadv = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic end_cycle();
    @(negedge clk); cs = 1'b1; nwe = 1'b1; noe = 1'b1; db_in = 16'h0;
    repeat (2) @(negedge clk);
  endtask

  // lat = posedges from the NWE rise until wr_stb is seen, 0 if never.
  task automatic fmc_write(input logic [15:0] a, input logic [15:0] d, output int lat);
    addr_phase(a);
    db_in = d; nwe = 1'b0;
    repeat (5) @(negedge clk); nwe = 1'b1;
    lat = 0;
    for (int i = 1; i <= 8 && lat == 0; i++) begin
      @(posedge clk); #1;
      if (wr_stb) lat = i;
    end
    end_cycle();
  endtask

  task automatic fmc_read(input logic [15:0] a, output int lat_req, output int lat_oe,
                          output logic [15:0] dout, output logic oe_after);
    addr_phase(a);
    db_in = 16'h0; noe = 1'b0;
    lat_req = 0; lat_oe = 0;
    for (int i = 1; i <= 10 && lat_oe == 0; i++) begin
      @(posedge clk); #1;
      if (rd_req && lat_req == 0) lat_req = i;
      if (db_oe) lat_oe = i;
    end
    dout = db_out;
    @(negedge clk); noe = 1'b1; #1;
    oe_after = db_oe;
    end_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, lat_req, lat_oe, w0, r0, e0;
    logic [15:0] dout;
    logic oe_after;

    rst = 1'b1; cs = 1'b1; nadv = 1'b1; nwe = 1'b1; noe = 1'b1; db_in = 16'h0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check_eq("reset_pulses", 32'({wr_stb, rd_req, bus_err, db_oe}), 32'h0);
    check_eq("reset_db_out", 32'(db_out), 32'h0);
    check_eq("reset_addr_data", 32'({wr_addr, rd_addr, wr_data}), 32'h0);

    // Write 0xA5A5 to channel 3.
    w0 = wr_cnt;
    fmc_write(16'h0003, 16'hA5A5, lat);
    check_eq("wr_latency", 32'(lat), 32'(NS + 1));
    check_eq("wr_count", 32'(wr_cnt - w0), 32'd1);
    check_eq("wr_payload", 32'(wr_q[wr_q.size() - 1]), 32'h3A5A5);
    fmc_write(16'h000F, 16'hBEEF, lat);
    check_eq("wr15_payload", 32'(wr_q[wr_q.size() - 1]), 32'hFBEEF);

    // Read channel 15.
    r0 = rd_cnt;
    fmc_read(16'h000F, lat_req, lat_oe, dout, oe_after);
    check_eq("rd_latency", 32'(lat_req), 32'(NS + 1));
    check_eq("rd_count", 32'(rd_cnt - r0), 32'd1);
    check_eq("rd_addr", 32'(rd_q[rd_q.size() - 1]), 32'hF);
    check_eq("rd_oe_seen", 32'(lat_oe != 0), 32'd1);
    check_eq("rd_db_out", 32'(dout), 32'hBEEF);
    check_eq("rd_oe_release", 32'(oe_after), 32'd0);

    // Out-of-range address, then a valid write to 0.
    w0 = wr_cnt; e0 = err_cnt;
    fmc_write(16'h0010, 16'h1234, lat);
    check_eq("oor_err", 32'(err_cnt - e0), 32'd1);
    check_eq("oor_no_wr", 32'(wr_cnt - w0), 32'd0);
    fmc_write(16'h0000, 16'h5555, lat);
    check_eq("after_oor_wr", 32'(wr_cnt - w0), 32'd1);
    check_eq("after_oor_payload", 32'(wr_q[wr_q.size() - 1]), 32'h05555);

    // NWE and NOE low together.
    w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt; oe_seen = 1'b0;
    addr_phase(16'h0002);
    nwe = 1'b0; noe = 1'b0;
    repeat (6) @(negedge clk);
    end_cycle();
    check_eq("both_err", 32'(err_cnt - e0), 32'd1);
    check_eq("both_no_wr_rd", 32'((wr_cnt - w0) + (rd_cnt - r0)), 32'd0);
    check_eq("both_oe", 32'(oe_seen), 32'd0);

    // Chip select released during the NWE-low phase.
    w0 = wr_cnt; e0 = err_cnt;
    addr_phase(16'h0004);
    db_in = 16'h7777; nwe = 1'b0;
    repeat (2) @(negedge clk); cs = 1'b1;
    @(negedge clk); nwe = 1'b1;
    repeat (6) @(negedge clk);
    check_eq("abort_no_wr", 32'(wr_cnt - w0), 32'd0);
    check_eq("abort_no_err", 32'(err_cnt - e0), 32'd0);
    check_eq("abort_idle", 32'(dut.state), 32'(S_IDLE));

    // Reset in the middle of a read of channel 3.
    addr_phase(16'h0003);
    db_in = 16'h0; noe = 1'b0;
    lat_oe = 0;
    for (int i = 1; i <= 10 && lat_oe == 0; i++) begin
      @(posedge clk); #1;
      if (db_oe) lat_oe = i;
    end
    check_eq("rst_rd_data", 32'(db_out), 32'hA5A5);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check_eq("rst_mid_pulses", 32'({wr_stb, rd_req, bus_err, db_oe}), 32'h0);
    check_eq("rst_mid_db_out", 32'(db_out), 32'h0);
    check_eq("rst_mid_addr_data", 32'({wr_addr, rd_addr, wr_data}), 32'h0);
    @(negedge clk); cs = 1'b1; noe = 1'b1; nadv = 1'b1;
    repeat (3) @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);

    // Back-to-back: 16 writes then 16 reads.
    wr_q.delete(); rd_q.delete();
    for (int i = 0; i < 16; i++) fmc_write(16'(i), 16'h1000 + 16'(i), lat);
    check_eq("b2b_wr_count", 32'(wr_q.size()), 32'd16);
    for (int i = 0; i < 16 && i < wr_q.size(); i++)
      check_eq("b2b_wr_payload", 32'(wr_q[i]), 32'({4'(i), 16'h1000 + 16'(i)}));
    for (int i = 0; i < 16; i++) begin
      fmc_read(16'(i), lat_req, lat_oe, dout, oe_after);
      check_eq("b2b_rd_data", 32'(dout), 32'(16'h1000 + 16'(i)));
    end
    check_eq("b2b_rd_count", 32'(rd_q.size()), 32'd16);
    for (int i = 0; i < 16 && i < rd_q.size(); i++)
      check_eq("b2b_rd_addr", 32'(rd_q[i]), 32'(i));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
